// File: rtl/diff_core_pkg.sv
// Shared constants and types for the diffusion core datapath: psum buffer
// geometry and the write-back scheduler state encoding.
package diff_core_pkg;

    // Psum buffer is double-banked so the producer can fill one bank while the
    // write-back unit drains the other.
    localparam int PSUM_BANKS = 2;

    // Number of banks the write-back scheduler alternates between.
    localparam int WB_BANKS = PSUM_BANKS;

    typedef enum logic [2:0] {
        WB_IDLE      = 3'd0,
        WB_WAIT_BANK = 3'd1,
        WB_ISSUE     = 3'd2,
        WB_RUN       = 3'd3,
        WB_DONE      = 3'd4
    } wb_sched_state_t;

    // One-hot mask selecting a single bank.
    function automatic logic [WB_BANKS-1:0] bank_mask(input logic bank);
        logic [WB_BANKS-1:0] m;
        m       = {WB_BANKS{1'b0}};
        m[bank] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_scheduler_if.sv
// Job, bank and write-back control signals of the write-back scheduler.
// slave  : the scheduler's view (accepts jobs, commands the write-back unit)
// master : the surrounding environment's view
interface wb_scheduler_if;
    import diff_core_pkg::*;

    logic                job_valid;
    logic                job_ready;
    logic [7:0]          job_groups_i;
    logic [15:0]         job_pace_i;
    logic                job_bit_mode_i;
    logic [WB_BANKS-1:0] bank_fill_i;
    logic [WB_BANKS-1:0] bank_full_o;
    logic [WB_BANKS-1:0] bank_release_o;
    logic                wb_ctrl_valid;
    logic                wb_ctrl_ready;
    logic                wb_ctrl_finish;
    logic [15:0]         wb_pace_o;
    logic                wb_bit_mode_o;
    logic                wb_bank_sel_o;
    logic                job_done_o;
    logic                busy_o;
    logic                overflow_o;

    modport slave (
        input  job_valid, job_groups_i, job_pace_i, job_bit_mode_i,
        input  bank_fill_i, wb_ctrl_ready, wb_ctrl_finish,
        output job_ready, bank_full_o, bank_release_o, wb_ctrl_valid,
        output wb_pace_o, wb_bit_mode_o, wb_bank_sel_o, job_done_o,
        output busy_o, overflow_o
    );

    modport master (
        output job_valid, job_groups_i, job_pace_i, job_bit_mode_i,
        output bank_fill_i, wb_ctrl_ready, wb_ctrl_finish,
        input  job_ready, bank_full_o, bank_release_o, wb_ctrl_valid,
        input  wb_pace_o, wb_bit_mode_o, wb_bank_sel_o, job_done_o,
        input  busy_o, overflow_o
    );

endinterface

// File: rtl/wb_bank_tracker.sv
// Psum bank occupancy tracker. A bank becomes full on a producer fill pulse
// and empty on a consumer release pulse; a fill that lands on a bank that is
// still full (and not being released that same cycle) latches a sticky
// overflow flag. Fill wins over a coincident release.
module wb_bank_tracker
    import diff_core_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WB_BANKS-1:0] fill_i,
    input  logic [WB_BANKS-1:0] release_i,
    output logic [WB_BANKS-1:0] full_o,
    output logic                overflow_o
);

    logic [WB_BANKS-1:0] full_r;
    logic                overflow_r;

    // Update bank occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r     <= {WB_BANKS{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            full_r <= (full_r & ~release_i) | fill_i;
            if (|(fill_i & full_r & ~release_i)) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign full_o     = full_r;
    assign overflow_o = overflow_r;

endmodule

// File: rtl/wb_scheduler.sv
// Write-back scheduler: accepts a job of N channel groups and, for each
// group, waits for the current psum bank to fill, commands the write-back
// unit, waits for it to finish, releases the bank and moves to the other
// bank. The current bank survives across jobs so producer and consumer
// stay in lockstep.
module wb_scheduler
    import diff_core_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    wb_scheduler_if.slave  bus
);

    wb_sched_state_t     state_r;
    logic                cur_bank_r;
    logic [7:0]          remaining_r;
    logic [15:0]         pace_r;
    logic                bit_mode_r;
    logic                job_ready_r;
    logic                busy_r;
    logic                ctrl_valid_r;
    logic                job_done_r;
    logic [WB_BANKS-1:0] release_r;

    logic [WB_BANKS-1:0] bank_full_s;
    logic                overflow_s;

    wb_bank_tracker u_bank_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill_i     (bus.bank_fill_i),
        .release_i  (release_r),
        .full_o     (bank_full_s),
        .overflow_o (overflow_s)
    );

    // Scheduler FSM with all status/command outputs registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= WB_IDLE;
            cur_bank_r   <= 1'b0;
            remaining_r  <= 8'd0;
            pace_r       <= 16'd0;
            bit_mode_r   <= 1'b0;
            job_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            ctrl_valid_r <= 1'b0;
            job_done_r   <= 1'b0;
            release_r    <= {WB_BANKS{1'b0}};
        end else begin
            // Pulses default low and are raised only on their event.
            job_done_r <= 1'b0;
            release_r  <= {WB_BANKS{1'b0}};
            case (state_r)
                WB_IDLE: begin
                    if (bus.job_valid) begin
                        remaining_r <= bus.job_groups_i;
                        pace_r      <= bus.job_pace_i;
                        bit_mode_r  <= bus.job_bit_mode_i;
                        job_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (bus.job_groups_i == 8'd0) begin
                            state_r <= WB_DONE;
                        end else begin
                            state_r <= WB_WAIT_BANK;
                        end
                    end else begin
                        state_r <= WB_IDLE;
                    end
                end
                WB_WAIT_BANK: begin
                    if (bank_full_s[cur_bank_r]) begin
                        state_r      <= WB_ISSUE;
                        ctrl_valid_r <= 1'b1;
                    end else begin
                        state_r <= WB_WAIT_BANK;
                    end
                end
                WB_ISSUE: begin
                    if (bus.wb_ctrl_ready) begin
                        state_r      <= WB_RUN;
                        ctrl_valid_r <= 1'b0;
                    end else begin
                        state_r <= WB_ISSUE;
                    end
                end
                WB_RUN: begin
                    if (bus.wb_ctrl_finish) begin
                        release_r   <= bank_mask(cur_bank_r);
                        cur_bank_r  <= ~cur_bank_r;
                        remaining_r <= remaining_r - 8'd1;
                        if (remaining_r == 8'd1) begin
                            state_r <= WB_DONE;
                        end else begin
                            state_r <= WB_WAIT_BANK;
                        end
                    end else begin
                        state_r <= WB_RUN;
                    end
                end
                WB_DONE: begin
                    job_done_r  <= 1'b1;
                    job_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= WB_IDLE;
                end
                default: begin
                    state_r      <= WB_IDLE;
                    ctrl_valid_r <= 1'b0;
                    job_ready_r  <= 1'b1;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.job_ready      = job_ready_r;
    assign bus.busy_o         = busy_r;
    assign bus.wb_ctrl_valid  = ctrl_valid_r;
    assign bus.job_done_o     = job_done_r;
    assign bus.bank_release_o = release_r;
    assign bus.bank_full_o    = bank_full_s;
    assign bus.overflow_o     = overflow_s;
    assign bus.wb_pace_o      = pace_r;
    assign bus.wb_bit_mode_o  = bit_mode_r;
    assign bus.wb_bank_sel_o  = cur_bank_r;

endmodule

// File: tb/tb_wb_scheduler.sv
// Bench for wb_scheduler: directed scenarios with literal expectations plus a
// long randomized run, all checked every cycle against a behavioural model.
module tb_wb_scheduler;

    logic clk = 1'b0;
    logic rst_n;

    wb_scheduler_if bus();

    wb_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: job phase, passes left, bank occupancy.
    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_ISSUE = 2;
    localparam int P_RUN   = 3;
    localparam int P_DONE  = 4;

    int          m_phase;
    int          m_left;
    logic        m_cur;
    logic [15:0] m_pace;
    logic        m_mode;
    logic [1:0]  m_full;
    logic [1:0]  m_rel;
    logic        m_ovf;
    logic        m_done;

    // Observed-event logs used by the directed scenarios.
    int         hs_count;
    int         done_count;
    logic       hs_bank[$];
    logic [1:0] rel_log[$];

    task automatic model_reset();
        m_phase = P_IDLE; m_left = 0; m_cur = 1'b0; m_pace = 16'd0;
        m_mode = 1'b0; m_full = 2'b00; m_rel = 2'b00; m_ovf = 1'b0; m_done = 1'b0;
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        logic [1:0] fill;
        logic [1:0] old_full;
        logic [1:0] nrel;
        logic       ndone;
        fill     = bus.bank_fill_i;
        old_full = m_full;
        nrel     = 2'b00;
        ndone    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (fill[i] && m_full[i] && !m_rel[i]) m_ovf = 1'b1;
        end
        m_full = (m_full & ~m_rel) | fill;
        case (m_phase)
            P_IDLE: if (bus.job_valid) begin
                m_left  = int'(bus.job_groups_i);
                m_pace  = bus.job_pace_i;
                m_mode  = bus.job_bit_mode_i;
                m_phase = (m_left == 0) ? P_DONE : P_WAIT;
            end
            P_WAIT:  if (old_full[m_cur]) m_phase = P_ISSUE;
            P_ISSUE: if (bus.wb_ctrl_ready) m_phase = P_RUN;
            P_RUN: if (bus.wb_ctrl_finish) begin
                nrel[m_cur] = 1'b1;
                m_cur       = ~m_cur;
                m_left      = m_left - 1;
                m_phase     = (m_left == 0) ? P_DONE : P_WAIT;
            end
            P_DONE: begin
                ndone   = 1'b1;
                m_phase = P_IDLE;
            end
            default: m_phase = P_IDLE;
        endcase
        m_rel  = nrel;
        m_done = ndone;
    endtask

    // Per-cycle comparison of every output against the model, plus event logs.
    always @(negedge clk) begin
        logic [26:0] exp_v;
        logic [26:0] act_v;
        exp_v = {m_phase == P_IDLE, m_phase != P_IDLE, m_phase == P_ISSUE, m_done,
                 m_rel, m_full, m_ovf, m_cur, m_mode, m_pace};
        act_v = {bus.job_ready, bus.busy_o, bus.wb_ctrl_valid, bus.job_done_o,
                 bus.bank_release_o, bus.bank_full_o, bus.overflow_o,
                 bus.wb_bank_sel_o, bus.wb_bit_mode_o, bus.wb_pace_o};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_cmp t=%0t: got %07h expected %07h", $time, act_v, exp_v);
        end
        if (bus.wb_ctrl_valid && bus.wb_ctrl_ready) begin
            hs_count++;
            hs_bank.push_back(bus.wb_bank_sel_o);
        end
        if (|bus.bank_release_o) rel_log.push_back(bus.bank_release_o);
        if (bus.job_done_o) done_count++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        #1;
        bus.job_valid      = 1'b0;
        bus.bank_fill_i    = 2'b00;
        bus.wb_ctrl_finish = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        hs_count = 0; done_count = 0;
        hs_bank.delete(); rel_log.delete();
    endtask

    task automatic start_job(input logic [7:0] g, input logic [15:0] p, input logic md);
        bus.job_valid = 1'b1; bus.job_groups_i = g; bus.job_pace_i = p; bus.job_bit_mode_i = md;
        tick();
    endtask

    initial begin
        logic [31:0] v;
        rst_n = 1'b0;
        bus.job_valid = 1'b0; bus.job_groups_i = 8'd0; bus.job_pace_i = 16'd0;
        bus.job_bit_mode_i = 1'b0; bus.bank_fill_i = 2'b00;
        bus.wb_ctrl_ready = 1'b0; bus.wb_ctrl_finish = 1'b0;
        model_reset();
        clear_logs();
        do_reset();

        // Two-group job across both banks, with first-command latency.
        clear_logs();
        chk("reset_ready", 32'(bus.job_ready), 32'd1);
        chk("reset_busy", 32'(bus.busy_o), 32'd0);
        chk("reset_full", 32'(bus.bank_full_o), 32'd0);
        bus.bank_fill_i = 2'b01; tick();
        start_job(8'd2, 16'd5, 1'b0);
        chk("lat_t1_valid", 32'(bus.wb_ctrl_valid), 32'd0);
        tick();
        chk("lat_t2_valid", 32'(bus.wb_ctrl_valid), 32'd1);
        chk("issue0_sel", 32'(bus.wb_bank_sel_o), 32'd0);
        chk("issue0_pace", 32'(bus.wb_pace_o), 32'd5);
        bus.wb_ctrl_ready = 1'b1; tick(); bus.wb_ctrl_ready = 1'b0;
        tick(); tick();
        bus.wb_ctrl_finish = 1'b1; tick();
        chk("rel0_pulse", 32'(bus.bank_release_o), 32'd1);
        bus.bank_fill_i = 2'b10; tick();
        bus.wb_ctrl_ready = 1'b1; repeat (3) tick(); bus.wb_ctrl_ready = 1'b0;
        bus.wb_ctrl_finish = 1'b1; tick();
        tick(); tick();
        chk("two_job_hs", 32'(hs_count), 32'd2);
        v = (hs_bank.size() == 2) ? 32'({hs_bank[0], hs_bank[1]}) : 32'hFFFF;
        chk("two_job_banks", v, 32'h1);
        v = (rel_log.size() == 2) ? 32'({rel_log[0], rel_log[1]}) : 32'hFFFF;
        chk("two_job_rels", v, 32'h6);
        chk("two_job_done", 32'(done_count), 32'd1);

        // Zero-group job completes without any command.
        clear_logs();
        start_job(8'd0, 16'h1234, 1'b0);
        chk("zero_t1_done", 32'(bus.job_done_o), 32'd0);
        chk("zero_t1_busy", 32'(bus.busy_o), 32'd1);
        tick();
        chk("zero_t2_done", 32'(bus.job_done_o), 32'd1);
        chk("zero_t2_ready", 32'(bus.job_ready), 32'd1);
        tick();
        chk("zero_t3_done", 32'(bus.job_done_o), 32'd0);
        chk("zero_no_cmd", 32'(hs_count), 32'd0);

        // Back-pressure in ISSUE keeps the command stable.
        bus.bank_fill_i = 2'b01; tick();
        start_job(8'd1, 16'hBEEF, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(bus.wb_ctrl_valid), 32'd1);
            chk("stall_pace", 32'(bus.wb_pace_o), 32'hBEEF);
            chk("stall_sel", 32'(bus.wb_bank_sel_o), 32'd0);
            tick();
        end
        bus.wb_ctrl_ready = 1'b1; tick(); bus.wb_ctrl_ready = 1'b0;
        bus.wb_ctrl_finish = 1'b1; tick();
        tick(); tick();
        chk("sel_toggled", 32'(bus.wb_bank_sel_o), 32'd1);

        // Double fill without release sets overflow.
        do_reset();
        chk("sel_after_reset", 32'(bus.wb_bank_sel_o), 32'd0);
        bus.bank_fill_i = 2'b01; tick();
        bus.bank_fill_i = 2'b01; tick();
        chk("ovf_set", 32'(bus.overflow_o), 32'd1);
        chk("ovf_full", 32'(bus.bank_full_o), 32'd1);

        // Fill coincident with release keeps the bank full, no overflow.
        do_reset();
        bus.bank_fill_i = 2'b01; tick();
        start_job(8'd1, 16'd7, 1'b0);
        tick();
        bus.wb_ctrl_ready = 1'b1; tick(); bus.wb_ctrl_ready = 1'b0;
        bus.wb_ctrl_finish = 1'b1; tick();
        chk("coinc_rel", 32'(bus.bank_release_o), 32'd1);
        bus.bank_fill_i = 2'b01; tick();
        chk("coinc_full", 32'(bus.bank_full_o), 32'd1);
        chk("coinc_no_ovf", 32'(bus.overflow_o), 32'd0);
        tick(); tick();

        // Reset during RUN abandons the job.
        do_reset();
        clear_logs();
        bus.bank_fill_i = 2'b01; tick();
        start_job(8'd3, 16'h00AA, 1'b1);
        tick();
        bus.wb_ctrl_ready = 1'b1; tick(); bus.wb_ctrl_ready = 1'b0;
        chk("run_busy", 32'(bus.busy_o), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_ready", 32'(bus.job_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_full", 32'(bus.bank_full_o), 32'd0);
        chk("rst_pace", 32'(bus.wb_pace_o), 32'd0);
        chk("rst_valid", 32'(bus.wb_ctrl_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(bus.job_ready), 32'd1);
        chk("rst_no_done", 32'(done_count), 32'd0);
        chk("rst_no_release", 32'(rel_log.size()), 32'd0);

        // Maximum group count runs all 255 passes.
        do_reset();
        clear_logs();
        start_job(8'd255, 16'h0F0F, 1'b0);
        for (int c = 0; c < 3000 && done_count == 0; c++) begin
            if (!m_full[m_cur]) bus.bank_fill_i[m_cur] = 1'b1;
            bus.wb_ctrl_ready  = 1'b1;
            bus.wb_ctrl_finish = 1'b1;
            tick();
        end
        bus.wb_ctrl_ready = 1'b0;
        tick();
        chk("max_done", 32'(done_count), 32'd1);
        chk("max_hs", 32'(hs_count), 32'd255);
        chk("max_rel", 32'(rel_log.size()), 32'd255);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bus.job_valid      = ($urandom_range(0, 3) == 0);
            bus.job_groups_i   = 8'($urandom_range(0, 4));
            bus.job_pace_i     = 16'($urandom);
            bus.job_bit_mode_i = 1'($urandom_range(0, 1));
            for (int b = 0; b < 2; b++) begin
                if (!m_full[b]) bus.bank_fill_i[b] = ($urandom_range(0, 5) == 0);
                else            bus.bank_fill_i[b] = ($urandom_range(0, 80) == 0);
            end
            bus.wb_ctrl_ready  = ($urandom_range(0, 2) != 0);
            bus.wb_ctrl_finish = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        bus.wb_ctrl_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_scheduler.md
WB_SCHEDULER -- requirements
Module: wb_scheduler

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 job_valid  in  1  job descriptor valid.
REQ-004 job_ready  out  1  scheduler can accept a job.
REQ-005 job_groups_i  in  8  number of channel groups (write-back passes) in the job.
REQ-006 job_pace_i  in  16  pace value forwarded to the write-back unit for every group.
REQ-007 job_bit_mode_i  in  1  4-bit packing mode, forwarded.
REQ-008 bank_fill_i  in  2  one-cycle pulse per psum bank: producer finished filling bank i.
REQ-009 bank_full_o  out  2  bank i holds unconsumed psums.
REQ-010 bank_release_o  out  2  one-cycle pulse: bank i consumed, free for producer.
REQ-011 wb_ctrl_valid  out  1  command to write-back unit.
REQ-012 wb_ctrl_ready  in  1  write-back unit accepts command.
REQ-013 wb_ctrl_finish  in  1  write-back unit pass complete (one-cycle pulse).
REQ-014 wb_pace_o / wb_bit_mode_o  out  16/1  latched job fields.
REQ-015 wb_bank_sel_o  out  1  bank the write-back unit reads.
REQ-016 job_done_o  out  1  one-cycle pulse at job end.
REQ-017 busy_o  out  1  state != IDLE.
REQ-018 overflow_o  out  1  sticky error: fill pulse on an already-full bank.

Function
REQ-019 States SHALL be IDLE, WAIT_BANK, ISSUE, RUN, DONE.
REQ-020 job_ready SHALL equal (state == IDLE); on job_valid && job_ready, latch groups, pace, bit_mode.
REQ-021 IDLE -> DONE if latched groups == 0; else IDLE -> WAIT_BANK.
REQ-022 WAIT_BANK -> ISSUE when bank_full_o[cur_bank] == 1.
REQ-023 ISSUE: wb_ctrl_valid = 1, held until wb_ctrl_ready; on handshake -> RUN.
REQ-024 RUN: on wb_ctrl_finish, pulse bank_release_o[cur_bank], toggle cur_bank, decrement remaining; remaining reaches 0 -> DONE, else -> WAIT_BANK.
REQ-025 wb_ctrl_finish outside RUN SHALL be ignored.
REQ-026 DONE: job_done_o = 1 for exactly one cycle, then -> IDLE.
REQ-027 wb_bank_sel_o SHALL equal cur_bank; cur_bank persists across jobs, cleared only by reset.
REQ-028 bank_full_o[i] set on bank_fill_i[i], cleared on release of bank i; simultaneous fill and release of the same bank leaves it full (set wins).
REQ-029 bank_fill_i[i] while bank_full_o[i] == 1 and not released the same cycle SHALL set overflow_o; state unaffected.
REQ-030 Latency: job accepted cycle T with bank 0 already full -> wb_ctrl_valid high at T+2.
REQ-031 remaining counter 8-bit, no wrap; groups = 255 completes 255 passes.

Reset
REQ-032 rst_n low SHALL asynchronously force: state IDLE, cur_bank 0, remaining 0, bank_full_o 0, overflow_o 0, latched fields 0, all pulses/valids 0; job_ready 1 on first cycle after deassertion.
REQ-033 Reset mid-job abandons the job without job_done_o or bank_release_o.

Structure
REQ-034 wb_sched_state_t enum and WB_BANKS = 2 SHALL live in diff_core_pkg alongside the existing psum buffer constants.
REQ-035 Bank occupancy tracking SHALL be a sub-module wb_bank_tracker (fill/release/overflow logic).

Verification
REQ-036 Job groups=2, pace=5, fill bank0 then bank1 -> two ctrl handshakes on banks 0,1, releases 0 then 1, one job_done_o.
REQ-037 Job groups=0 -> job_done_o two cycles after accept, no wb_ctrl_valid.
REQ-038 wb_ctrl_ready held low 10 cycles in ISSUE -> wb_ctrl_valid stays high, pace/bank_sel stable.
REQ-039 bank_fill_i=2'b01 twice with no release -> overflow_o = 1, bank_full_o = 2'b01.
REQ-040 Release of bank0 coincident with bank_fill_i[0] -> bank_full_o[0] remains 1, no overflow.
REQ-041 rst_n asserted in RUN -> all outputs at reset values next edge, job_ready = 1 after release.
